// File: rtl/frame_bit_serializer_pkg.sv
// Shared definitions for the frame bit serializer.
// Holds the FSM state encoding, the byte and CRC widths, the CRC-32/MPEG-2
// initial register value used by the attached CRC engine, and the width of
// the shared bit/CRC counter.
package frame_bit_serializer_pkg;

  localparam int          BYTE_W   = 8;
  localparam int          CRC_W    = 32;
  localparam int          CNT_W    = 5;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_DATA  = 3'd2,
    ST_STALL = 3'd3,
    ST_FLUSH = 3'd4,
    ST_CRC   = 3'd5
  } state_e;

endpackage

// File: rtl/frame_bit_serializer.sv
// Frame bit serializer.
// Accepts payload bytes over a valid/ready handshake and shifts them out MSB
// first, both to an external bit-serial CRC engine and to the serial line.
// After the final byte, it captures the CRC engine register and appends its
// 32 bits (MSB first) to the serial line, flagging the last one.
// Ports:
//   clk_in, rst_in         clock, asynchronous active-high reset
//   byte_in/_valid/_last   payload byte stream, byte_ready_out handshake
//   crc_rst_out            one-cycle clear of the downstream CRC engine
//   bit_out, bit_valid_out payload bit stream into the CRC engine
//   crc_in                 CRC engine register value
//   tx_bit_out/_valid/_last serial line: payload then CRC
//   busy_out               high whenever a frame is in progress
// Every output is decoded from registered state only.
module frame_bit_serializer
  import frame_bit_serializer_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid_in,
  input  logic              byte_last_in,
  output logic              byte_ready_out,
  output logic              crc_rst_out,
  output logic              bit_out,
  output logic              bit_valid_out,
  input  logic [CRC_W-1:0]  crc_in,
  output logic              tx_bit_out,
  output logic              tx_valid_out,
  output logic              tx_last_out,
  output logic              busy_out
);

  state_e             state_r, state_nxt_s;
  logic [CNT_W-1:0]   count_r, count_nxt_s;
  logic [BYTE_W-1:0]  shreg_r, shreg_nxt_s;
  logic [CRC_W-1:0]   crcsh_r, crcsh_nxt_s;
  logic               last_flag_r, last_flag_nxt_s;
  // live_r keeps byte_ready_out low while reset is held even though the
  // state register already reads IDLE; it rises on the first clock after
  // reset is released.
  logic               live_r;
  logic               ready_s;
  logic               accept_s;

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r     <= ST_IDLE;
      count_r     <= '0;
      shreg_r     <= '0;
      crcsh_r     <= '0;
      last_flag_r <= 1'b0;
      live_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      shreg_r     <= shreg_nxt_s;
      crcsh_r     <= crcsh_nxt_s;
      last_flag_r <= last_flag_nxt_s;
      live_r      <= 1'b1;
    end
  end

  // Next-state logic and output decode.
  always_comb begin
    state_nxt_s     = state_r;
    count_nxt_s     = count_r;
    shreg_nxt_s     = shreg_r;
    crcsh_nxt_s     = crcsh_r;
    last_flag_nxt_s = last_flag_r;
    ready_s         = 1'b0;
    crc_rst_out     = 1'b0;
    bit_out         = 1'b0;
    bit_valid_out   = 1'b0;
    tx_bit_out      = 1'b0;
    tx_valid_out    = 1'b0;
    tx_last_out     = 1'b0;
    busy_out        = (state_r != ST_IDLE);

    // Ready depends on state only; a new byte can join mid-frame only on
    // the last bit of the current byte so the stream has no bubble.
    case (state_r)
      ST_IDLE:  ready_s = live_r;
      ST_DATA: begin
        if ((count_r == 5'd7) && !last_flag_r) begin
          ready_s = 1'b1;
        end else begin
          ready_s = 1'b0;
        end
      end
      ST_STALL: ready_s = 1'b1;
      default:  ready_s = 1'b0;
    endcase
    accept_s       = byte_valid_in & ready_s;
    byte_ready_out = ready_s;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          shreg_nxt_s     = byte_in;
          last_flag_nxt_s = byte_last_in;
          count_nxt_s     = 5'd0;
          state_nxt_s     = ST_INIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        crc_rst_out = 1'b1;
        count_nxt_s = 5'd0;
        state_nxt_s = ST_DATA;
      end
      ST_DATA: begin
        bit_out       = shreg_r[BYTE_W-1];
        bit_valid_out = 1'b1;
        tx_bit_out    = shreg_r[BYTE_W-1];
        tx_valid_out  = 1'b1;
        shreg_nxt_s   = {shreg_r[BYTE_W-2:0], 1'b0};
        count_nxt_s   = count_r + 5'd1;
        if (count_r == 5'd7) begin
          count_nxt_s = 5'd0;
          if (accept_s) begin
            shreg_nxt_s     = byte_in;
            last_flag_nxt_s = byte_last_in;
            state_nxt_s     = ST_DATA;
          end else if (last_flag_r) begin
            state_nxt_s = ST_FLUSH;
          end else begin
            state_nxt_s = ST_STALL;
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_STALL: begin
        if (accept_s) begin
          shreg_nxt_s     = byte_in;
          last_flag_nxt_s = byte_last_in;
          count_nxt_s     = 5'd0;
          state_nxt_s     = ST_DATA;
        end else begin
          state_nxt_s = ST_STALL;
        end
      end
      ST_FLUSH: begin
        // The CRC engine has absorbed the final payload bit by now.
        crcsh_nxt_s = crc_in;
        count_nxt_s = 5'd0;
        state_nxt_s = ST_CRC;
      end
      ST_CRC: begin
        tx_bit_out   = crcsh_r[CRC_W-1];
        tx_valid_out = 1'b1;
        crcsh_nxt_s  = {crcsh_r[CRC_W-2:0], 1'b0};
        count_nxt_s  = count_r + 5'd1;
        if (count_r == 5'd31) begin
          tx_last_out = 1'b1;
          count_nxt_s = 5'd0;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CRC;
        end
      end
      default: begin
        count_nxt_s = 5'd0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_frame_bit_serializer.sv
// Bench for frame_bit_serializer with a bit-serial CRC-32/MPEG-2 engine
// attached. A driver pushes the expected serial stream into a scoreboard
// queue as bytes are accepted; a monitor pops and compares every valid bit.
module tb_frame_bit_serializer;
  import frame_bit_serializer_pkg::*;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  byte_in;
  logic        byte_valid_in, byte_last_in, byte_ready_out;
  logic        crc_rst_out, bit_out, bit_valid_out;
  logic [31:0] crc_in;
  logic        tx_bit_out, tx_valid_out, tx_last_out, busy_out;

  always #5 clk_in = ~clk_in;

  frame_bit_serializer dut (
    .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in),
    .byte_valid_in(byte_valid_in), .byte_last_in(byte_last_in),
    .byte_ready_out(byte_ready_out), .crc_rst_out(crc_rst_out),
    .bit_out(bit_out), .bit_valid_out(bit_valid_out), .crc_in(crc_in),
    .tx_bit_out(tx_bit_out), .tx_valid_out(tx_valid_out),
    .tx_last_out(tx_last_out), .busy_out(busy_out)
  );

  // Bit-serial CRC engine (the downstream block).
  logic [31:0] crc_eng_r;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) crc_eng_r <= 32'h0;
    else if (crc_rst_out) crc_eng_r <= CRC_INIT;
    else if (bit_valid_out)
      crc_eng_r <= {crc_eng_r[30:0], 1'b0} ^ (((crc_eng_r[31] ^ bit_out) == 1'b1) ? POLY : 32'h0);
  end
  assign crc_in = crc_eng_r;

  typedef struct packed { logic b; logic last; logic pay; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] frame_q[$];

  int total = 0, bad = 0;
  int cyc = 0;
  int bit_idx = 0, last_frame_bits = 0, last_cyc = 0, init_cyc = 0, frames_done = 0;
  int accept_cyc = 0;
  logic [31:0] crc_acc = 32'h0, last_crc = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference CRC: byte-at-a-time textbook form over the whole frame.
  function automatic logic [31:0] crc_ref();
    logic [31:0] c;
    c = CRC_INIT;
    foreach (frame_q[i]) begin
      c = c ^ {frame_q[i], 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) exp_q.push_back('{b: b[k], last: 1'b0, pay: 1'b1});
  endtask

  task automatic push_crc(input logic [31:0] c);
    for (int k = 31; k >= 0; k--) exp_q.push_back('{b: c[k], last: (k == 0), pay: 1'b0});
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: compares every presented bit against the scoreboard.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_in) begin
      bit_idx = 0;
      crc_acc = 32'h0;
    end else begin
      if (crc_rst_out) init_cyc = cyc;
      if (tx_valid_out) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_tx: got bit %0b with empty scoreboard", tx_bit_out);
        end else begin
          e = exp_q.pop_front();
          check("tx_stream", {29'h0, tx_bit_out, tx_last_out, bit_valid_out}, {29'h0, e.b, e.last, e.pay});
          if (bit_valid_out) check("bit_out_eq_tx", {31'h0, bit_out}, {31'h0, tx_bit_out});
        end
        bit_idx++;
        if (!bit_valid_out) crc_acc = {crc_acc[30:0], tx_bit_out};
        if (tx_last_out) begin
          last_frame_bits = bit_idx;
          last_crc = crc_acc;
          last_cyc = cyc;
          frames_done++;
          bit_idx = 0;
        end
      end else begin
        check("quiet_when_no_tx", {30'h0, bit_valid_out, tx_last_out}, 32'h0);
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!byte_ready_out && n < 300);
    if (!byte_ready_out) begin
      total++; bad++;
      $display("FAIL %s_timeout: ready still %0b after %0d cycles", name, byte_ready_out, n);
    end
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (frames_done <= prev && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    if (frames_done <= prev) begin
      total++; bad++;
      $display("FAIL frame_done_timeout: frames_done=%0d needed >%0d", frames_done, prev);
    end
  endtask

  // Drives frame_q; optional stall of gap_len cycles after byte gap_after.
  task automatic send_frame(input int gap_after, input int gap_len);
    bit ready_known;
    ready_known = 1'b0;
    @(posedge clk_in); #1;
    for (int i = 0; i < frame_q.size(); i++) begin
      byte_in = frame_q[i];
      byte_last_in = (i == frame_q.size() - 1);
      byte_valid_in = 1'b1;
      if (!ready_known) wait_ready("accept");
      ready_known = 1'b0;
      if (i == 0) accept_cyc = cyc;
      @(posedge clk_in);
      push_byte(frame_q[i]);
      #1;
      if (i == gap_after && gap_len > 0 && i < frame_q.size() - 1) begin
        byte_valid_in = 1'b0;
        wait_ready("byte_end");
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk_in);
          check("stall_cycle", {28'h0, byte_ready_out, busy_out, tx_valid_out, bit_valid_out}, 32'hC);
        end
        ready_known = 1'b1;
      end
    end
    byte_valid_in = 1'b0;
    byte_last_in = 1'b0;
    push_crc(crc_ref());
  endtask

  task automatic load_ascii();
    frame_q.delete();
    for (int k = 0; k < 9; k++) frame_q.push_back(8'h31 + k[7:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, n, viol, t1, len;
    rst_in = 1'b1; byte_in = 8'h0; byte_valid_in = 1'b0; byte_last_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("outputs_in_reset", {24'h0, byte_ready_out, crc_rst_out, bit_out, bit_valid_out,
          tx_bit_out, tx_valid_out, tx_last_out, busy_out}, 32'h0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("ready_after_reset", {30'h0, byte_ready_out, busy_out}, 32'h2);

    // "123456789" with no gaps.
    load_ascii(); d = frames_done;
    send_frame(-1, 0);
    wait_done(d);
    check("ascii_crc", last_crc, 32'h0376_E6E7);
    check("ascii_bits", last_frame_bits, 104);
    check("ascii_latency", last_cyc - accept_cyc, 8 * 9 + 34);

    // Same frame with a 5-cycle stall after byte 3.
    load_ascii(); d = frames_done;
    send_frame(2, 5);
    wait_done(d);
    check("stall_crc", last_crc, 32'h0376_E6E7);

    // Single byte 0xA5 while byte_valid_in stays high through the frame.
    frame_q.delete(); frame_q.push_back(8'hA5); d = frames_done;
    @(posedge clk_in); #1;
    byte_in = 8'hA5; byte_last_in = 1'b1; byte_valid_in = 1'b1;
    wait_ready("single");
    accept_cyc = cyc;
    @(posedge clk_in);
    push_byte(8'hA5);
    push_crc(crc_ref());
    #1 byte_in = 8'h3C;
    n = 0; viol = 0;
    do begin
      @(negedge clk_in);
      if (busy_out) begin
        n++;
        if (byte_ready_out) viol++;
      end
    end while (busy_out && n < 100);
    byte_valid_in = 1'b0;
    byte_last_in = 1'b0;
    check("single_busy_cycles", n, 42);
    check("no_ready_while_busy", viol, 0);
    check("single_done", frames_done, d + 1);
    check("single_latency", last_cyc - accept_cyc, 8 + 34);

    // Reset during CRC bit 10 then a clean frame.
    load_ascii(); d = frames_done;
    send_frame(-1, 0);
    n = 0; t1 = 0;
    while (n < 10 && t1 < 500) begin
      @(negedge clk_in);
      t1++;
      if (tx_valid_out && !bit_valid_out) n++;
    end
    check("reached_crc_bit10", n, 10);
    #1 rst_in = 1'b1;
    #1 check("outputs_on_reset", {24'h0, byte_ready_out, crc_rst_out, bit_out, bit_valid_out,
             tx_bit_out, tx_valid_out, tx_last_out, busy_out}, 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk_in);
    check("no_last_after_abort", frames_done, d);
    rst_in = 1'b0;
    load_ascii(); d = frames_done;
    send_frame(-1, 0);
    wait_done(d);
    check("post_reset_crc", last_crc, 32'h0376_E6E7);
    check("post_reset_bits", last_frame_bits, 104);

    // Back-to-back frames.
    frame_q.delete();
    for (int k = 0; k < 3; k++) frame_q.push_back(8'($urandom));
    d = frames_done;
    send_frame(-1, 0);
    load_ascii();
    send_frame(-1, 0);
    t1 = last_cyc;
    check("b2b_first_done", frames_done, d + 1);
    check("b2b_accept_gap", accept_cyc - t1, 1);
    check("b2b_init_gap", init_cyc - t1, 2);
    wait_done(d + 1);
    check("b2b_second_crc", last_crc, 32'h0376_E6E7);

    // Randomized frames with optional stalls.
    for (int f = 0; f < 8; f++) begin
      int ga, gl;
      len = $urandom_range(1, 6);
      frame_q.delete();
      for (int k = 0; k < len; k++) frame_q.push_back(8'($urandom));
      ga = $urandom_range(0, len - 1);
      gl = $urandom_range(0, 3);
      d = frames_done;
      send_frame(ga, gl);
      wait_done(d);
      check("rand_crc", last_crc, crc_ref());
      if (gl == 0 || ga == len - 1) check("rand_latency", last_cyc - accept_cyc, 8 * len + 34);
    end

    repeat (5) @(negedge clk_in);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
